fpdiv_ctrl: RTL
===============

// Module: fpdiv_ctrl
//
// PURPOSE
// Control FSM for the fpdiv Goldschmidt datapath.
// - Sequences the datapath controls sel_mux3, sel_mux4, en_a, en_b and en_rem.
// - Pass 1: scale the numerator and the denominator by the initial approximation (IA).
// - Passes 2..NUM_ITER: refine using the correction factor held in register C.
// - Final cycle: load the remainder register.
// - Sits directly upstream of fpdiv. Start/done handshake toward the FP issue logic.
//
// PARAMETERS
// NUM_ITER  6  total Goldschmidt passes, including the IA pass; legal range 2..(2**CNT_W)-1
// CNT_W     3  width of the pass counter
//
// PORTS
// clk       in   1  clock; all state changes on the rising edge
// reset     in   1  synchronous, active-high reset
// start     in   1  request a divide; sampled only in IDLE or DONE
// rm_in     in   2  rounding mode; captured on an accepted start
// busy      out  1  high while a divide sequence is running (IA_A..REM)
// done      out  1  one-cycle pulse; the fpdiv result/remainder registers are valid
// sel_mux3  out  2  fpdiv mux3 select: 00 = IA, 01 = reg C, 10 = remainder path
// sel_mux4  out  2  fpdiv mux4 select: 00 = N*IA, 01 = D*IA, 10 = A-path iterate, 11 = B-path iterate
// en_a      out  1  load enable, fpdiv register A
// en_b      out  1  load enable, fpdiv register B
// en_rem    out  1  load enable, fpdiv remainder register
// rm        out  2  captured rounding mode, held stable from accept until the next accept
// iter      out  CNT_W  current pass number (1..NUM_ITER); 0 when idle
//
// BEHAVIOUR
// - Reset (synchronous, active-high) forces the following on the next edge:
//   - state = IDLE, iter = 0, rm = 00
//   - sel_mux3 = 00, sel_mux4 = 00
//   - en_a = en_b = en_rem = 0, busy = 0, done = 0
// - Reset asserted mid-sequence aborts the sequence on that edge. No further enables are
//   issued. Reset overrides start.
// - Moore machine. Every output is decoded from the registered state and counter, with no
//   combinational path from start. Outputs change only on clock edges.
// - State table (outputs are sel_mux3 / sel_mux4 / en_a en_b en_rem):
//   - IDLE : 00 / 00 / 0 0 0
//     - start=1 -> IA_A; rm <= rm_in; iter <= 1
//   - IA_A : 00 / 00 / 1 0 0 -> IA_B
//   - IA_B : 00 / 01 / 0 1 0
//     - -> IT_A if NUM_ITER > 1; iter <= 2
//   - IT_A : 01 / 10 / 1 0 0 -> IT_B
//   - IT_B : 01 / 11 / 0 1 0
//     - -> IT_A with iter <= iter + 1 if iter < NUM_ITER
//     - -> REM otherwise
//   - REM  : 10 / 10 / 0 0 1 -> DONE
//   - DONE : 10 / 10 / 0 0 0, done = 1, iter = 0
//     - start=1 -> IA_A (back-to-back accept, rm recaptured)
//     - start=0 -> IDLE
// - busy = 1 in IA_A, IA_B, IT_A, IT_B and REM. done is never high together with busy.
// - Latency, counted with cycle 0 = the first busy cycle after the accepting edge:
//   - en_a in cycles 0, 2, ..., 2*NUM_ITER-2
//   - en_b in cycles 1, 3, ..., 2*NUM_ITER-1
//   - en_rem in cycle 2*NUM_ITER
//   - done in cycle 2*NUM_ITER+1
// - en_a, en_b and en_rem are mutually exclusive in every cycle (one-hot or all zero).
// - start while busy is ignored. There is no queueing, and rm holds its captured value.
// - iter never exceeds NUM_ITER, and the counter never wraps.
// - An illegal or unreachable state encoding recovers to IDLE on the next edge, with all
//   enables low.
//
// TESTING
// 1. Reset: reset=1 for 2 cycles with start=1 -> all outputs 0, state IDLE; no enable
//    pulses while reset is held.
// 2. NUM_ITER=6, single start pulse with rm_in=2'b10:
//    - en_a in cycles 0,2,4,6,8,10; en_b in cycles 1,3,5,7,9,11; en_rem in cycle 12;
//      done in cycle 13
//    - sel_mux4 sequence 00,01,10,11,...,10 and sel_mux3 sequence 00,00,01,...,10
//    - rm = 10 throughout
// 3. start held high for 30 cycles -> back-to-back sequences of 14 cycles each with no
//    IDLE gap; starts during busy are ignored; rm is recaptured at each DONE.
// 4. reset asserted in cycle 5 of a sequence (IT_B, iter=3) -> next edge is IDLE with all
//    enables 0; a new start then yields a full, correct 14-cycle sequence.
// 5. NUM_ITER=2 build -> en_a at cycles 0,2; en_b at 1,3; en_rem at 4; done at 5.
//    Run with fpdiv attached for N=1.2464, D=1.8456: the A register converges to 0.67534
//    within 1 ulp of the 27-bit result.
// 6. Assertion checks every cycle: at most one enable high; done implies !busy; iter <= NUM_ITER.

Source files
------------

// File: rtl/fpdiv_ctrl_if.sv
// Start/done handshake and fpdiv datapath controls
// between the FP issue logic and the divider controller.
interface fpdiv_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             start;
  logic [1:0]       rm_in;
  logic             busy;
  logic             done;
  logic [1:0]       sel_mux3;
  logic [1:0]       sel_mux4;
  logic             en_a;
  logic             en_b;
  logic             en_rem;
  logic [1:0]       rm;
  logic [CNT_W-1:0] iter;

  modport master (
    output start, rm_in,
    input  busy, done, sel_mux3, sel_mux4,
    input  en_a, en_b, en_rem, rm, iter
  );

  modport slave (
    input  start, rm_in,
    output busy, done, sel_mux3, sel_mux4,
    output en_a, en_b, en_rem, rm, iter
  );
endinterface

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divide sequencer: IA pass, NUM_ITER-1
// refinement passes, remainder load, one-cycle done.
module fpdiv_ctrl #(
  parameter int NUM_ITER = 6,
  parameter int CNT_W    = 3
) (
  input logic        clk,
  input logic        reset,
  fpdiv_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IA_A = 3'd1,
    S_IA_B = 3'd2,
    S_IT_A = 3'd3,
    S_IT_B = 3'd4,
    S_REM  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LP_NITER = CNT_W'(NUM_ITER);
  localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_TWO   = CNT_W'(2);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_iter;
  logic [CNT_W-1:0] w_iter_nxt;
  logic [1:0]       r_rm;
  logic [1:0]       w_rm_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_rm    <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_iter  <= w_iter_nxt;
      r_rm    <= w_rm_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    w_iter_nxt  = '0;
    w_rm_nxt    = r_rm;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = S_IA_A;
          w_iter_nxt  = LP_ONE;
          w_rm_nxt    = bus.rm_in;
        end
      end
      S_IA_A: begin
        w_state_nxt = S_IA_B;
        w_iter_nxt  = r_iter;
      end
      S_IA_B: begin
        w_state_nxt = S_IT_A;
        w_iter_nxt  = LP_TWO;
      end
      S_IT_A: begin
        w_state_nxt = S_IT_B;
        w_iter_nxt  = r_iter;
      end
      S_IT_B: begin
        // saturating compare keeps iter within 1..NUM_ITER
        if (r_iter < LP_NITER) begin
          w_state_nxt = S_IT_A;
          w_iter_nxt  = r_iter + LP_ONE;
        end else begin
          w_state_nxt = S_REM;
          w_iter_nxt  = r_iter;
        end
      end
      S_REM: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.sel_mux3 = 2'b00;
    bus.sel_mux4 = 2'b00;
    bus.en_a     = 1'b0;
    bus.en_b     = 1'b0;
    bus.en_rem   = 1'b0;
    case (r_state)
      S_IA_A: begin
        bus.busy = 1'b1;
        bus.en_a = 1'b1;
      end
      S_IA_B: begin
        bus.busy     = 1'b1;
        bus.sel_mux4 = 2'b01;
        bus.en_b     = 1'b1;
      end
      S_IT_A: begin
        bus.busy     = 1'b1;
        bus.sel_mux3 = 2'b01;
        bus.sel_mux4 = 2'b10;
        bus.en_a     = 1'b1;
      end
      S_IT_B: begin
        bus.busy     = 1'b1;
        bus.sel_mux3 = 2'b01;
        bus.sel_mux4 = 2'b11;
        bus.en_b     = 1'b1;
      end
      S_REM: begin
        bus.busy     = 1'b1;
        bus.sel_mux3 = 2'b10;
        bus.sel_mux4 = 2'b10;
        bus.en_rem   = 1'b1;
      end
      S_DONE: begin
        bus.done     = 1'b1;
        bus.sel_mux3 = 2'b10;
        bus.sel_mux4 = 2'b10;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.rm   = r_rm;
  assign bus.iter = r_iter;
endmodule
